// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch PC writer: branch encodings, MDU tracker states and defaults.
package pc_ctrl_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_J    = 3'd3;
  localparam logic [2:0] BR_JR   = 3'd4;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  // Also the reset value of the F_PC register.
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic {
    StIdle,
    StBusy
  } md_state_e;

endpackage

// File: rtl/md_busy_tracker.sv
// Multiply/divide busy tracker: a down-counter loaded on each MDU start, busy until it expires.
module md_busy_tracker import pc_ctrl_pkg::*; #(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // A start while already busy simply restarts the window.
    if (start) begin
      cnt_d   = is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
      state_d = StBusy;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = StIdle;
      end
    end
  end

  assign busy = start | (state_q == StBusy);

endmodule

// File: rtl/pc_ctrl.sv
// Fetch PC writer: resolves D-stage branch/jump targets and merges MDU and data-hazard stalls.
module pc_ctrl import pc_ctrl_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_PC,
  input  logic [31:0] D_PC,
  input  logic [2:0]  D_br_type,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_rs_val,
  input  logic [31:0] D_rt_val,
  input  logic        D_data_stall,
  input  logic        D_is_md,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic [31:0] NPC,
  output logic        PCWrEn,
  output logic        FD_WrEn,
  output logic        DE_clr,
  output logic        md_busy
);

  logic [31:0] seq_pc, br_tgt, j_tgt, npc_sel;
  logic        ops_eq, stall;

  md_busy_tracker #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_tracker (
    .clk    (clk),
    .reset  (reset),
    .start  (E_md_start),
    .is_div (E_md_is_div),
    .busy   (md_busy)
  );

  // Branch offsets are relative to the delay slot (D_PC + 4).
  assign seq_pc = F_PC + 32'd4;
  assign br_tgt = D_PC + 32'd4 + {{14{D_imm26[15]}}, D_imm26[15:0], 2'b00};
  assign j_tgt  = {D_PC[31:28], D_imm26, 2'b00};
  assign ops_eq = (D_rs_val == D_rt_val);

  always_comb begin
    npc_sel = seq_pc;
    case (D_br_type)
      BR_BEQ:  npc_sel = ops_eq ? br_tgt : seq_pc;
      BR_BNE:  npc_sel = ops_eq ? seq_pc : br_tgt;
      BR_J:    npc_sel = j_tgt;
      BR_JR:   npc_sel = D_rs_val;
      default: npc_sel = seq_pc;
    endcase
  end

  // The target is recomputed every cycle; a stall just drops the PC write.
  assign stall = D_data_stall | (D_is_md & md_busy);

  always_comb begin
    NPC     = npc_sel;
    PCWrEn  = ~stall;
    FD_WrEn = ~stall;
    DE_clr  = stall;
    if (reset) begin
      NPC     = RESET_PC;
      PCWrEn  = 1'b1;
      FD_WrEn = 1'b1;
      DE_clr  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed plan cases plus randomized traffic against a reference model.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_PC, D_PC, D_rs_val, D_rt_val;
  logic [2:0]  D_br_type;
  logic [25:0] D_imm26;
  logic        D_data_stall, D_is_md, E_md_start, E_md_is_div;
  logic [31:0] NPC;
  logic        PCWrEn, FD_WrEn, DE_clr, md_busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state: index of the last cycle md_busy holds from an earlier start.
  int cyc      = 0;
  int busy_end = -1;

  logic [35:0] exp_q[$];
  string       tag_q[$];
  bit          stim_done = 1'b0;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .F_PC         (F_PC),
    .D_PC         (D_PC),
    .D_br_type    (D_br_type),
    .D_imm26      (D_imm26),
    .D_rs_val     (D_rs_val),
    .D_rt_val     (D_rt_val),
    .D_data_stall (D_data_stall),
    .D_is_md      (D_is_md),
    .E_md_start   (E_md_start),
    .E_md_is_div  (E_md_is_div),
    .NPC          (NPC),
    .PCWrEn       (PCWrEn),
    .FD_WrEn      (FD_WrEn),
    .DE_clr       (DE_clr),
    .md_busy      (md_busy)
  );

  function automatic logic [31:0] model_npc(input logic [31:0] fpc, input logic [31:0] dpc,
                                             input logic [2:0] bt, input logic [25:0] imm,
                                             input logic [31:0] rs, input logic [31:0] rt);
    logic signed [31:0] off;
    logic [31:0] tgt;
    off = $signed(imm[15:0]);
    tgt = dpc + 32'd4 + 32'(off * 4);
    case (bt)
      3'd1:    return (rs == rt) ? tgt : fpc + 32'd4;
      3'd2:    return (rs != rt) ? tgt : fpc + 32'd4;
      3'd3:    return (dpc & 32'hF000_0000) | {4'd0, imm, 2'b00};
      3'd4:    return rs;
      default: return fpc + 32'd4;
    endcase
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, then advance the model past the edge.
  task automatic step(input string tag, input logic rst, input logic [31:0] fpc,
                      input logic [31:0] dpc, input logic [2:0] bt, input logic [25:0] imm,
                      input logic [31:0] rs, input logic [31:0] rt, input logic dstall,
                      input logic ismd, input logic start, input logic isdiv);
    logic        busy, stl;
    logic [31:0] npc;
    reset = rst; F_PC = fpc; D_PC = dpc; D_br_type = bt; D_imm26 = imm;
    D_rs_val = rs; D_rt_val = rt; D_data_stall = dstall; D_is_md = ismd;
    E_md_start = start; E_md_is_div = isdiv;
    busy = start || (cyc <= busy_end);
    stl  = dstall || (ismd && busy);
    npc  = model_npc(fpc, dpc, bt, imm, rs, rt);
    if (rst) exp_q.push_back({32'h0000_3000, 1'b1, 1'b1, 1'b1, busy});
    else     exp_q.push_back({npc, !stl, !stl, stl, busy});
    tag_q.push_back(tag);
    if (rst)        busy_end = -1;
    else if (start) busy_end = cyc + (isdiv ? 10 : 5);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input string tag, input logic ismd);
    step(tag, 1'b0, 32'h3000, 32'h3000, 3'd0, 26'd0, 32'd0, 32'd0, 1'b0, ismd, 1'b0, 1'b0);
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle with the oldest queued expectation.
  initial begin
    logic [35:0] exp_v, act_v;
    string tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        act_v = {NPC, PCWrEn, FD_WrEn, DE_clr, md_busy};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL %s: got npc=%h pcwr=%b fdwr=%b declr=%b busy=%b, want npc=%h pcwr=%b fdwr=%b declr=%b busy=%b",
                   tag, act_v[35:4], act_v[3], act_v[2], act_v[1], act_v[0],
                   exp_v[35:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; F_PC = '0; D_PC = '0; D_br_type = '0; D_imm26 = '0;
    D_rs_val = '0; D_rt_val = '0; D_data_stall = 1'b0; D_is_md = 1'b0;
    E_md_start = 1'b0; E_md_is_div = 1'b0;
    // Unchecked settling cycles so the tracker state is defined.
    repeat (2) @(posedge clk);
    #1;

    step("reset", 1'b1, 32'h3000, 32'h3000, 3'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("seq", 1'b0, 32'h3000, 32'h2FFC, 3'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("beq_taken", 1'b0, 32'h3014, 32'h3010, 3'd1, 26'h000FFFE, 32'd7, 32'd7,
         1'b0, 1'b0, 1'b0, 1'b0);
    step("beq_untaken", 1'b0, 32'h3014, 32'h3010, 3'd1, 26'h000FFFE, 32'd7, 32'd8,
         1'b0, 1'b0, 1'b0, 1'b0);
    step("bne_taken", 1'b0, 32'h3014, 32'h3010, 3'd2, 26'h000FFFE, 32'd7, 32'd8,
         1'b0, 1'b0, 1'b0, 1'b0);
    step("j", 1'b0, 32'h3024, 32'h3020, 3'd3, 26'h0000C10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("jr", 1'b0, 32'h3024, 32'h3020, 3'd4, 26'd0, 32'h3100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("br_type7", 1'b0, 32'h3024, 32'h3020, 3'd7, 26'h3FFFFFF, 32'd1, 32'd1,
         1'b0, 1'b0, 1'b0, 1'b0);

    step("mult_start", 1'b0, 32'h3000, 32'h3000, 3'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (7) idle("mult_window", 1'b1);
    step("div_start", 1'b0, 32'h3000, 32'h3000, 3'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) idle("div_nonmd", 1'b0);
    repeat (9) idle("div_window", 1'b1);
    step("data_stall", 1'b0, 32'h3000, 32'h3000, 3'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    step("div_start2", 1'b0, 32'h3000, 32'h3000, 3'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) idle("div_pre_reset", 1'b1);
    step("reset_mid", 1'b1, 32'h3000, 32'h3000, 3'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) idle("after_reset", 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] rs, rt;
      rs = $urandom();
      rt = ($urandom_range(0, 1) == 0) ? rs : $urandom();
      step("random", ($urandom_range(0, 39) == 0), $urandom(), $urandom(),
           3'($urandom_range(0, 7)), 26'($urandom()), rs, rt,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1));
    end

    stim_done = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
